display_read_port: RTL and testbench
====================================

// Module: display_read_port
// PURPOSE
//  Memory-side responder for the display controller's private read path (the
//  display "back door" port of memMux). Accepts cache-line read requests
//  (readReq/RA), arbitrates for the DDR controller and issues one command per
//  line. Strips the zero byte from each 32-bit 0,r,g,b pixel word and returns
//  each line as two 96-bit RD words. Bypasses the ring, which cannot sustain
//  display bandwidth.
// PARAMETERS
//  MAX_OUT    8    max cache lines issued to DDR but not fully returned (1..15)
//  ADDR_W     26   cache-line address width
// PORTS
//  clock        in   1    system clock; all logic on posedge
//  reset        in   1    synchronous, active-high
//  readReq      in   1    display requests the line at RA
//  RA           in   26   cache-line address of the request
//  readAck      out  1    request accepted this cycle (combinational)
//  RD           out  96   four 24-bit pixels {p3,p2,p1,p0}, p0 in [23:0]
//  RDready      out  1    RD valid, 1-cycle pulse per 96-bit word
//  memReq       out  1    request to memMux DDR arbiter
//  memAddr      out  26   line address presented with memReq
//  memGrant     in   1    arbiter accepts the command this cycle
//  memRdData    in   128  DDR read beat: four 32-bit words 0,r,g,b, word0 in [31:0]
//  memRdValid   in   1    memRdData valid; two beats per line, in order
// BEHAVIOUR
//  Reset: readAck=0, RDready=0, RD=0, memReq=0, memAddr=0, outstanding=0,
//   beat=0, state=IDLE.
//  FSM, 2 states:
//   IDLE: readAck = readReq & (outstanding < MAX_OUT). On ack, latch RA into
//    memAddr and go to REQ.
//   REQ: memReq=1 and memAddr held stable until memGrant. On memGrant, go to
//    IDLE and increment outstanding. readAck=0 in REQ.
//  Peak rate: one line per 2 cycles when memGrant is immediate.
//  Return path: each memRdValid beat produces, one cycle later,
//   RD = {d[119:96],d[87:64],d[55:32],d[23:0]} and RDready=1.
//   Bits d[127:120], d[95:88], d[63:56], d[31:24] are ignored.
//   beat toggles per accepted beat. On the 2nd beat, decrement outstanding.
//  Grant and 2nd-beat completion in the same cycle: outstanding unchanged.
//  Beat arriving with outstanding==0 and beat==0 is discarded: no RDready, no
//   counter change. Outstanding never underflows.
//  Outstanding==MAX_OUT: readAck held 0. readReq may stay high indefinitely.
//  Worst-case readAck-to-last-RDready latency must be < 1000 cycles: the
//   display drops in-flight data for 1024 cycles at frame end.
//  Reset mid-operation: all state cleared next cycle. A partial line is
//   abandoned. No RDready in the cycle after reset.
//  RD retains its last value when RDready=0.
// CONFIGURATION
//  DISP_RD_STATS_EN defined: adds outputs
//   lineCount[31:0]   lines fully returned; wraps at 2^32
//   stallCount[31:0]  cycles with readReq=1 & readAck=0
//   dropCount[15:0]   discarded beats; saturates at 0xFFFF
//   All three clear on reset.
//  DISP_RD_STATS_EN undefined: these ports and counters do not exist.
//   Datapath behaviour is identical either way.
// TESTING
//  1 Single line: readReq with RA=0x1000000, memGrant next cycle, beats
//    0x00A1B2C3 x4 then 0x00010203 x4
//    -> readAck 1 cycle; memAddr=0x1000000; RD=0xA1B2C3A1B2C3A1B2C3A1B2C3 then
//    0x010203010203010203010203; RDready 1 cycle after each beat.
//  2 Back-pressure: memGrant held 0 for 20 cycles
//    -> memReq and memAddr stable; readAck=0 throughout; accepted on grant.
//  3 Limit: 8 grants with no data returned -> readAck stays 0 with readReq=1.
//    Then 2 beats return -> readAck reasserts next cycle.
//  4 Coincident: grant and 2nd beat in the same cycle with outstanding=3
//    -> outstanding stays 3.
//  5 Stray beat: memRdValid with outstanding=0 -> no RDready; dropCount=1
//    (with DISP_RD_STATS_EN).
//  6 Reset after 1st beat of a line -> next cycle RDready=0, memReq=0,
//    outstanding=0; next request completes normally.

Source files
------------

// File: rtl/display_read_port_if.sv
// display_read_port_if: display-side request/return and DDR arbiter signals of the display read port.
// master = display/memMux side, slave = the port itself.
interface display_read_port_if #(
    parameter int ADDR_W = 26
);
    logic              readReq;
    logic [ADDR_W-1:0] RA;
    logic              readAck;
    logic [95:0]       RD;
    logic              RDready;
    logic              memReq;
    logic [ADDR_W-1:0] memAddr;
    logic              memGrant;
    logic [127:0]      memRdData;
    logic              memRdValid;

    modport master (
        output readReq, RA, memGrant, memRdData, memRdValid,
        input  readAck, RD, RDready, memReq, memAddr
    );

    modport slave (
        input  readReq, RA, memGrant, memRdData, memRdValid,
        output readAck, RD, RDready, memReq, memAddr
    );
endinterface

// File: rtl/display_read_port.sv
// display_read_port: display back-door line reader; issues one DDR command per line, packs 0rgb words to 24-bit pixels.
// Define DISP_RD_STATS_EN to add lineCount/stallCount/dropCount statistics outputs.
module display_read_port #(
    parameter int MAX_OUT = 8,
    parameter int ADDR_W  = 26
) (
    input  logic                clock,
    input  logic                reset,
    display_read_port_if.slave  bus
`ifdef DISP_RD_STATS_EN
    ,
    output logic [31:0]         lineCount,
    output logic [31:0]         stallCount,
    output logic [15:0]         dropCount
`endif
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t            state, stateNext;
    logic [3:0]        outstanding;
    logic              beat;
    logic [ADDR_W-1:0] addrReg;
    logic              accept, lineDone, grant;
    logic              unusedPad;

    // A beat belongs to a granted line only if something is outstanding or a line is half-received.
    assign accept    = bus.memRdValid & ((outstanding != 4'd0) | beat);
    assign lineDone  = accept & beat;
    assign grant     = (state == REQ) & bus.memGrant;
    assign bus.memAddr = addrReg;
    assign unusedPad = ^{bus.memRdData[127:120], bus.memRdData[95:88],
                         bus.memRdData[63:56], bus.memRdData[31:24]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            outstanding <= 4'd0;
            beat        <= 1'b0;
            addrReg     <= '0;
            bus.RD      <= '0;
            bus.RDready <= 1'b0;
        end else begin
            state       <= stateNext;
            outstanding <= outstanding + {3'd0, grant} - {3'd0, lineDone};
            beat        <= beat ^ accept;
            addrReg     <= bus.readAck ? bus.RA : addrReg;
            bus.RDready <= accept;
            bus.RD      <= accept ? {bus.memRdData[119:96], bus.memRdData[87:64],
                                     bus.memRdData[55:32], bus.memRdData[23:0]} : bus.RD;
        end
    end

    always_comb begin
        stateNext   = state;
        bus.readAck = 1'b0;
        bus.memReq  = 1'b0;
        if (state == IDLE) begin
            bus.readAck = bus.readReq & (outstanding < 4'(MAX_OUT));
            stateNext   = bus.readAck ? REQ : IDLE;
        end else begin
            bus.memReq = 1'b1;
            stateNext  = bus.memGrant ? IDLE : REQ;
        end
    end

`ifdef DISP_RD_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            lineCount  <= '0;
            stallCount <= '0;
            dropCount  <= '0;
        end else begin
            lineCount  <= lineCount + {31'd0, lineDone};
            stallCount <= stallCount + {31'd0, bus.readReq & ~bus.readAck};
            dropCount  <= dropCount + {15'd0, bus.memRdValid & ~accept & (dropCount != 16'hFFFF)};
        end
    end
`endif
endmodule

// File: tb/tb_display_read_port.sv
// tb_display_read_port: directed and random stimulus checked against a queue-based model of lines in flight.
module tb_display_read_port;
    localparam int MAX_OUT = 8;
    localparam int ADDR_W  = 26;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    display_read_port_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef DISP_RD_STATS_EN
    logic [31:0] lineCount, stallCount;
    logic [15:0] dropCount;
`endif

    display_read_port #(.MAX_OUT(MAX_OUT), .ADDR_W(ADDR_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
`ifdef DISP_RD_STATS_EN
        ,
        .lineCount(lineCount),
        .stallCount(stallCount),
        .dropCount(dropCount)
`endif
    );

    int compared = 0;
    int mismatched = 0;

    // model: lines granted but not fully returned, beats of the oldest line seen so far
    logic [ADDR_W-1:0] lineQ[$];
    int                rxBeats;
    bit                inReq;
    logic [ADDR_W-1:0] reqAddr;
    bit                expRdy;
    logic [95:0]       expRD;
    int                lines, stalls, drops;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        lineQ.delete();
        rxBeats = 0;
        inReq = 0;
        reqAddr = '0;
        expRdy = 0;
        expRD = '0;
        lines = 0;
        stalls = 0;
        drops = 0;
    endtask

    task automatic checkStats();
`ifdef DISP_RD_STATS_EN
        chk("lineCount", lineCount, 32'(lines));
        chk("stallCount", stallCount, 32'(stalls));
        chk("dropCount", dropCount, 16'(drops));
`endif
    endtask

    task automatic doReset();
        bus.readReq = 0; bus.RA = '0; bus.memGrant = 0; bus.memRdValid = 0; bus.memRdData = '0;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        clearModel();
        chk("rst_RDready", bus.RDready, 1'b0);
        chk("rst_RD", bus.RD, 96'd0);
        chk("rst_memReq", bus.memReq, 1'b0);
        chk("rst_memAddr", bus.memAddr, 26'd0);
        chk("rst_readAck", bus.readAck, 1'b0);
        checkStats();
    endtask

    task automatic step(input logic rq, input logic [ADDR_W-1:0] ra, input logic gr,
                        input logic rv, input logic [127:0] d);
        bit ack;
        bus.readReq = rq; bus.RA = ra; bus.memGrant = gr; bus.memRdValid = rv; bus.memRdData = d;
        #1;
        ack = !inReq && rq && lineQ.size() < MAX_OUT;
        chk("readAck", bus.readAck, ack);
        chk("memReq", bus.memReq, inReq);
        chk("memAddr", bus.memAddr, reqAddr);
        if (rq && !ack) stalls++;
        expRdy = 0;
        if (rv) begin
            if (lineQ.size() == 0 && rxBeats == 0) begin
                if (drops < 65535) drops++;
            end else begin
                expRdy = 1;
                for (int i = 0; i < 4; i++) expRD[24*i +: 24] = d[32*i +: 24];
                rxBeats++;
                if (rxBeats == 2) begin
                    void'(lineQ.pop_front());
                    rxBeats = 0;
                    lines++;
                end
            end
        end
        if (inReq && gr) begin
            lineQ.push_back(reqAddr);
            inReq = 0;
        end else if (ack) begin
            inReq = 1;
            reqAddr = ra;
        end
        @(posedge clock); #1;
        chk("RDready", bus.RDready, expRdy);
        chk("RD", bus.RD, expRD);
        checkStats();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0);
    endtask

    task automatic issueLine(input logic [ADDR_W-1:0] a);
        step(1, a, 0, 0, '0);
        step(0, '0, 1, 0, '0);
    endtask

    initial begin
        clearModel();
        doReset();

        // 1: single line
        step(1, 26'h1000000, 0, 0, '0);
        chk("t1_memAddr", bus.memAddr, 26'h1000000);
        step(0, '0, 1, 0, '0);
        step(0, '0, 0, 1, {4{32'h00A1B2C3}});
        chk("t1_rd0", bus.RD, 96'hA1B2C3A1B2C3A1B2C3A1B2C3);
        step(0, '0, 0, 1, {4{32'h00010203}});
        chk("t1_rd1", bus.RD, 96'h010203010203010203010203);
        idle(2);

        // 2: back-pressure for 20 cycles, readReq kept high
        step(1, 26'h0ABCDEF, 0, 0, '0);
        for (int i = 0; i < 20; i++) step(1, 26'h0123456, 0, 0, '0);
        chk("t2_memAddr", bus.memAddr, 26'h0ABCDEF);
        step(0, '0, 1, 0, '0);
        step(0, '0, 0, 1, {4{32'hFF112233}});
        step(0, '0, 0, 1, {4{32'hEE445566}});
        idle(1);

        // 3: outstanding limit
        doReset();
        for (int i = 0; i < MAX_OUT; i++) issueLine(26'(i * 64));
        for (int i = 0; i < 5; i++) step(1, 26'h3000, 0, 0, '0);
        step(1, 26'h3000, 0, 1, {4{32'h00123456}});
        step(1, 26'h3000, 0, 1, {4{32'h00654321}});
        bus.readReq = 1; #1;
        chk("t3_reassert", bus.readAck, 1'b1);
        step(1, 26'h3000, 0, 0, '0);
        step(0, '0, 1, 0, '0);

        // 4: grant coincident with line completion keeps outstanding
        doReset();
        for (int i = 0; i < 3; i++) issueLine(26'(i + 5));
        step(1, 26'h77, 0, 0, '0);
        step(0, '0, 0, 1, {4{32'h00AAAAAA}});
        step(0, '0, 1, 1, {4{32'h00BBBBBB}});
        for (int i = 0; i < MAX_OUT - 3; i++) issueLine(26'(i + 100));
        bus.readReq = 1; #1;
        chk("t4_full", bus.readAck, 1'b0);
        step(1, 26'h99, 0, 0, '0);

        // 5: stray beat
        doReset();
        step(0, '0, 0, 1, {4{32'h00DEAD00}});
        chk("t5_noRdy", bus.RDready, 1'b0);
`ifdef DISP_RD_STATS_EN
        chk("t5_drop", dropCount, 16'd1);
`endif

        // 6: reset after first beat, then a clean line
        doReset();
        issueLine(26'h155);
        step(0, '0, 0, 1, {4{32'h00C0FFEE}});
        doReset();
        issueLine(26'h2AA);
        step(0, '0, 0, 1, {4{32'h00111111}});
        step(0, '0, 0, 1, {4{32'h00222222}});
        chk("t6_rd", bus.RD, 96'h222222222222222222222222);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) doReset();
            else step(($urandom % 4) != 0, 26'($urandom), $urandom % 2,
                      ($urandom % 10) < 3, {$urandom, $urandom, $urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
